// File: rtl/fun_pkg.sv
// fun_pkg: shared definitions for the fun / fun_inv arithmetic cluster.
//   - FSM state encoding (legacy-compatible 3-bit constants)
//   - datapath widths X_W / D_W / Y_W
//   - cycle counts of the sequential multiplies
//   - sub_clamp(): unsigned subtract with underflow clamp to zero
package fun_pkg;

    localparam int X_W     = 8;    // fun output / offset width
    localparam int D_W     = 16;   // x^2 and x^2 - a width
    localparam int Y_W     = 48;   // (x^2 - a)^3 width
    localparam int SQ_CYC  = 8;    // x*x: one multiplier bit per cycle
    localparam int MUL_CYC = 16;   // d*d and p*d
    localparam int CNT_W   = 5;    // holds bit counts up to 16

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_SQ   = 3'd1;
    localparam state_t ST_SUB  = 3'd2;
    localparam state_t ST_MUL1 = 3'd3;
    localparam state_t ST_MUL2 = 3'd4;

    // Returns {underflow, d}. On underflow d is forced to zero so the caller
    // takes the same zero shortcut as an exact x^2 == a.
    function automatic logic [D_W:0] sub_clamp(input logic [D_W-1:0] s,
                                               input logic [X_W-1:0] a);
        logic uf;
        uf = (s < D_W'(a));
        return {uf, uf ? '0 : (s - D_W'(a))};
    endfunction

endpackage

// File: rtl/fun_inv_if.sv
// fun_inv_if: request/result bundle of fun_inv.
//   start_i : request pulse (sampled by the block only when idle)
//   x_bi    : value to invert
//   a_bi    : offset operand
//   busy_o  : computation in progress
//   y_bo    : registered result (x^2 - a)^3
//   err_o   : underflow flag (only when FUN_INV_ERR_EN is defined)
// modport slave  : the fun_inv block
// modport master : the requester
interface fun_inv_if;
    import fun_pkg::*;

    logic             start_i;
    logic [X_W-1:0]   x_bi;
    logic [X_W-1:0]   a_bi;
    logic             busy_o;
    logic [Y_W-1:0]   y_bo;
`ifdef FUN_INV_ERR_EN
    logic             err_o;

    modport slave  (input  start_i, x_bi, a_bi, output busy_o, y_bo, err_o);
    modport master (output start_i, x_bi, a_bi, input  busy_o, y_bo, err_o);
`else
    modport slave  (input  start_i, x_bi, a_bi, output busy_o, y_bo);
    modport master (output start_i, x_bi, a_bi, input  busy_o, y_bo);
`endif

endinterface

// File: rtl/fun_inv_mul_seq.sv
// mul_seq: iterative shift-add multiplier, one multiplier bit per cycle.
//   clk_i    : clock
//   rst_i    : asynchronous active-low reset, clears all registers
//   start_i  : load operands (takes priority over a step in progress)
//   mcand_i  : multiplicand, MUL_W bits
//   mplier_i : multiplier, up to 16 bits
//   nbits_i  : number of multiplier bits to process (= cycles)
//   busy_o   : steps remaining
//   last_o   : the current cycle processes the final bit
//   res_o    : product as it will be after this edge (equals the
//              registered product once idle); lets the caller chain the
//              next multiply on the same edge the last bit is consumed
module mul_seq #(
    parameter int MUL_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [MUL_W-1:0]     mcand_i,
    input  logic [15:0]          mplier_i,
    input  logic [4:0]           nbits_i,
    output logic                 busy_o,
    output logic                 last_o,
    output logic [MUL_W+15:0]    res_o
);
    localparam int P_W = MUL_W + 16;

    logic [P_W-1:0] acc;
    logic [P_W-1:0] mc_sh;   // multiplicand pre-shifted to the current bit weight
    logic [15:0]    mp;
    logic [4:0]     cnt;

    assign busy_o = (cnt != '0);
    assign last_o = (cnt == 5'd1);
    assign res_o  = (busy_o && mp[0]) ? (acc + mc_sh) : acc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc   <= '0;
            mc_sh <= '0;
            mp    <= '0;
            cnt   <= '0;
        end else if (start_i) begin
            acc   <= '0;
            mc_sh <= P_W'(mcand_i);
            mp    <= mplier_i;
            cnt   <= nbits_i;
        end else if (busy_o) begin
            acc   <= res_o;
            mc_sh <= mc_sh << 1;
            mp    <= mp >> 1;
            cnt   <= cnt - 5'd1;
        end
    end

endmodule

// File: rtl/fun_inv.sv
// fun_inv: sequential inverse of fun, y = (x^2 - a)^3, all unsigned.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset; abandons any operation
//   bus   : fun_inv_if.slave (start_i, x_bi, a_bi, busy_o, y_bo[, err_o])
// Parameter MUL_W (>= 32): multiplicand width of the shared multiplier.
// Optional feature macro FUN_INV_ERR_EN adds the err_o underflow flag.
//
// Schedule from the accepting edge E0: SQ E1..E8, SUB E9,
// MUL1 E10..E25, MUL2 E26..E41. A zero difference finishes at E9.
module fun_inv
    import fun_pkg::*;
#(
    parameter int MUL_W = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    fun_inv_if.slave  bus
);
    localparam int P_W = MUL_W + 16;

    state_t          state;
    logic [X_W-1:0]  a_q;     // x lives in the multiplier registers after E0
    logic [D_W-1:0]  d_q;     // kept for the second multiply
    logic [Y_W-1:0]  y_q;

    logic            mul_start;
    logic [MUL_W-1:0] mul_mc;
    logic [15:0]     mul_mp;
    logic [CNT_W-1:0] mul_nb;
    logic            mul_busy;
    logic            mul_last;
    logic [P_W-1:0]  mul_res;
    logic            mul_done;

    logic            uflow;
    logic [D_W-1:0]  d;

    mul_seq #(.MUL_W(MUL_W)) u_mul (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (mul_start),
        .mcand_i  (mul_mc),
        .mplier_i (mul_mp),
        .nbits_i  (mul_nb),
        .busy_o   (mul_busy),
        .last_o   (mul_last),
        .res_o    (mul_res)
    );

    assign mul_done = mul_busy & mul_last;

    // In SUB the multiplier is idle, so res_o is the registered x^2.
    assign {uflow, d} = sub_clamp(mul_res[D_W-1:0], a_q);

    // Multiplier load mux. MUL2 is loaded on the final MUL1 edge straight
    // from the combinational product so no idle cycle is inserted.
    always_comb begin
        mul_start = 1'b0;
        mul_mc    = '0;
        mul_mp    = '0;
        mul_nb    = '0;
        case (state)
            ST_IDLE: if (bus.start_i) begin
                mul_start = 1'b1;
                mul_mc    = MUL_W'(bus.x_bi);
                mul_mp    = 16'(bus.x_bi);
                mul_nb    = CNT_W'(SQ_CYC);
            end
            ST_SUB: if (d != '0) begin
                mul_start = 1'b1;
                mul_mc    = MUL_W'(d);
                mul_mp    = d;
                mul_nb    = CNT_W'(MUL_CYC);
            end
            ST_MUL1: if (mul_done) begin
                mul_start = 1'b1;
                mul_mc    = MUL_W'(mul_res[2*D_W-1:0]);
                mul_mp    = d_q;
                mul_nb    = CNT_W'(MUL_CYC);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            a_q   <= '0;
            d_q   <= '0;
            y_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start_i) begin
                    a_q   <= bus.a_bi;
                    state <= ST_SQ;
                end
                ST_SQ: if (mul_done) state <= ST_SUB;
                ST_SUB: begin
                    d_q <= d;
                    if (d == '0) begin
                        y_q   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_MUL1;
                    end
                end
                ST_MUL1: if (mul_done) state <= ST_MUL2;
                ST_MUL2: if (mul_done) begin
                    y_q   <= mul_res[Y_W-1:0];
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o = (state != ST_IDLE);
    assign bus.y_bo   = y_q;

`ifdef FUN_INV_ERR_EN
    logic err_q;

    // Updated only at SUB, so it holds across the following idle period.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            err_q <= 1'b0;
        else if (state == ST_SUB)
            err_q <= uflow;
    end

    assign bus.err_o = err_q;
`else
    // Underflow only steers the clamp inside sub_clamp.
    logic unused_uflow;
    assign unused_uflow = uflow;
`endif

endmodule

// File: doc/fun_inv.md
# fun_inv

Sequential inverse of the `fun` datapath: `fun` computes y = sqrt(a + cbrt(b)), and `fun_inv` computes b = (x² − a)³. Given an 8-bit result `x` and the same 8-bit offset `a`, it recovers the 48-bit argument that `fun` would map back to `x`. It uses a start/busy handshake and an iterative shift-add multiplier. It sits beside `fun` in the arithmetic cluster and is used for self-check and round-trip tests.

## Interface
- `MUL_W`, default 32: multiplicand width of the internal sequential multiplier. Must be ≥ 32.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  request pulse; sampled only in IDLE.
- `x_bi`  in  8  value to invert (output domain of `fun`).
- `a_bi`  in  8  offset operand (same meaning as in `fun`).
- `busy_o`  out  1  high while a computation is in progress.
- `y_bo`  out  48  result (x² − a)³, registered.
- `err_o`  out  1  underflow flag, x² < a. Present only with `FUN_INV_ERR_EN`.

## Operation
- FSM states: IDLE, SQ, SUB, MUL1, MUL2.
- IDLE: `busy_o` = 0. When `start_i` = 1, latch `x_bi`/`a_bi` and go to SQ. No other work is done in IDLE.
- SQ: compute s = x·x (16-bit) on the sequential multiplier, one multiplier bit per cycle, 8 cycles.
- SUB: form d = s − a (16-bit unsigned), 1 cycle.
  - If s < a: clamp d = 0 and set the underflow condition.
  - If d = 0: write `y_bo` = 0 and return to IDLE, skipping both multiplies.
  - Otherwise go to MUL1.
- MUL1: p = d·d (32-bit), 16 cycles.
- MUL2: y = p·d (48-bit), 16 cycles. On the last cycle, write `y_bo` = y and go to IDLE.
- Arithmetic: all unsigned. No truncation anywhere, because 65025³ < 2⁴⁸.
- `y_bo` holds the last result until the next completion. It is not cleared on start.
- `start_i` while busy: ignored. No queuing, and the latched operands are unchanged.
- Reset, asserted at any time (including mid-operation): FSM → IDLE, `busy_o` = 0, `y_bo` = 0, `err_o` = 0, multiplier registers cleared. The operation in progress is abandoned.

## Timing
- Start accepted at edge E0; `busy_o` = 1 from E0 until the completing edge.
- Normal latency: 8 + 1 + 16 + 16 = 41 cycles. `y_bo` is valid and `busy_o` = 0 after edge E41.
- Zero shortcut (d = 0, including the clamped case): 9 cycles. `y_bo` = 0 and `busy_o` = 0 after edge E9.
- `busy_o` and `y_bo` change on the same edge. The result may be sampled on the first cycle in which `busy_o` = 0.
- Back-to-back operation: `start_i` high on the first idle cycle is accepted. Minimum request spacing is therefore latency + 1 cycles.

## Configuration
- `FUN_INV_ERR_EN` defined:
  - Port `err_o` exists.
  - It is set at the SUB edge when x² < a, and cleared at the SUB edge of the next operation with x² ≥ a.
  - Reset value is 0.
- `FUN_INV_ERR_EN` undefined:
  - No `err_o` port and no flag register.
  - Underflow clamps silently to `y_bo` = 0.
  - All other timing is identical.

## Structure
- Shared package `fun_pkg`:
  - FSM state enum, sharing its encoding style with `fun`.
  - Widths `X_W` = 8, `D_W` = 16, `Y_W` = 48.
  - Cycle constants `SQ_CYC` = 8, `MUL_CYC` = 16.
- One sub-module, `mul_seq`:
  - Parameterized shift-add multiplier: multiplicand up to `MUL_W` bits, multiplier up to 16 bits.
  - Handshake is start/busy.
  - The bit count is a port, so the same instance serves SQ (8 bits), MUL1 (16 bits) and MUL2 (16 bits).
- `fun_inv` contains the FSM, operand latches, subtract/clamp and the result register.

## Test plan
- x=5, a=0 → d=25; `y_bo` = 15625; `busy_o` high exactly 41 cycles; `err_o` = 0.
- x=4, a=7 → `y_bo` = 729. Then immediately x=255, a=0 → `y_bo` = 274941996890625 (maximum value, no overflow).
- x=3, a=9 → d = 0; `y_bo` = 0 after 9 cycles; `err_o` = 0.
- x=2, a=10 → underflow; `y_bo` = 0 after 9 cycles; `err_o` = 1 (with `FUN_INV_ERR_EN`). The next request with x=5, a=0 clears `err_o`.
- Start x=5, a=0, then pulse `start_i` with x=9, a=1 at cycle 20 → ignored; result is still 15625 at cycle 41.
- Start x=5, a=0, then assert `rst_i` = 0 asynchronously mid-MUL1 → `busy_o` = 0 and `y_bo` = 0 immediately. After release, a new start x=4, a=7 → `y_bo` = 729 in 41 cycles.
